// File: rtl/osc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : osc_pkg
//  Description : Shared definitions for the gated oscillator divider:
//                per-channel state encoding, default build constants and a
//                helper that locates a channel's field in a packed bus.
//  Revision    : 1.0 - initial release
// ============================================================================
package osc_pkg;

    // Default build constants for the divider block
    localparam int c_def_nch         = 4;
    localparam int c_def_div_w       = 8;
    localparam int c_def_cnt_w       = 8;
    localparam int c_def_sync_stages = 2;

    // Per-channel controller state
    //   IDLE      : output parked low, waiting for a synchronised enable
    //   RUN       : divider toggling, enable present
    //   STOP_PEND : enable gone, finishing the current period
    //   DONE      : burst complete, waiting for the enable to drop
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        STOP_PEND = 2'd2,
        DONE      = 2'd3
    } osc_state_t;

    // Low bit index of channel 'chan' inside a packed bus of 'width'-bit fields
    function automatic int slice_lo(input int chan, input int width);
        return chan * width;
    endfunction

endpackage : osc_pkg
`default_nettype wire

// File: rtl/osc_div_chan.sv
`default_nettype none
// ============================================================================
//  Module      : osc_div_chan
//  Description : One channel of the gated oscillator divider. Synchronises
//                the asynchronous enable, runs a 50% duty divider with a
//                programmable half-period and optionally stops itself after
//                a fixed number of pulses. Start and stop only happen at
//                period boundaries so the output never carries a runt pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module osc_div_chan
    import osc_pkg::*;
#(
    parameter int DIV_W       = c_def_div_w,
    parameter int CNT_W       = c_def_cnt_w,
    parameter int SYNC_STAGES = c_def_sync_stages
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic [CNT_W-1:0] burst_i,
    output logic             out_o,
    output logic             active_o,
    output logic             done_o
);

    localparam logic [DIV_W-1:0] c_cnt_one  = DIV_W'(1);
    localparam logic [CNT_W-1:0] c_pcnt_one = CNT_W'(1);

    // Enable synchroniser chain; the last stage is the usable enable
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_en_s;

    // Channel state and datapath
    osc_state_t       r_state;
    osc_state_t       w_state_nxt;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] r_pcnt;
    logic [CNT_W-1:0] w_pcnt_nxt;
    logic [DIV_W-1:0] r_div_q;
    logic [DIV_W-1:0] w_div_nxt;
    logic [CNT_W-1:0] r_burst_q;
    logic [CNT_W-1:0] w_burst_nxt;
    logic             r_out;
    logic             w_out_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             r_active;

    // Free-running divider step, shared by every state that keeps it going
    logic             w_wrap;
    logic             w_eop;
    logic             w_burst_hit;
    logic [DIV_W-1:0] w_step_cnt;
    logic             w_step_out;
    logic [CNT_W-1:0] w_step_pcnt;

    assign w_en_s = r_sync[SYNC_STAGES-1];

    // Half-period boundary: the counter has reached the latched divide value
    assign w_wrap = (r_cnt == r_div_q);

    // End of a full period: low phase finishing, output would rise next
    assign w_eop = w_wrap && !r_out;

    // Burst length reached; a zero burst length means run forever
    assign w_burst_hit = (r_burst_q != '0) && (r_pcnt == r_burst_q);

    assign w_step_cnt  = w_wrap ? '0 : (r_cnt + c_cnt_one);
    assign w_step_out  = w_wrap ? ~r_out : r_out;
    // A pulse is counted when its high phase ends (falling edge)
    assign w_step_pcnt = (w_wrap && r_out) ? (r_pcnt + c_pcnt_one) : r_pcnt;

    // Shift the raw enable through the synchroniser
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], en_i};
        end
    end

    // Next-state, divider and configuration-latch decisions
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pcnt_nxt  = r_pcnt;
        w_out_nxt   = r_out;
        w_div_nxt   = r_div_q;
        w_burst_nxt = r_burst_q;
        w_done_nxt  = 1'b0;

        case (r_state)
            IDLE: begin
                w_cnt_nxt  = '0;
                w_pcnt_nxt = '0;
                w_out_nxt  = 1'b0;
                if (w_en_s) begin
                    // Configuration is frozen here for the whole run
                    w_state_nxt = RUN;
                    w_out_nxt   = 1'b1;
                    w_div_nxt   = div_i;
                    w_burst_nxt = burst_i;
                end
            end

            RUN: begin
                if (w_eop && w_burst_hit) begin
                    w_state_nxt = DONE;
                    w_cnt_nxt   = '0;
                    w_out_nxt   = 1'b0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt  = w_step_cnt;
                    w_out_nxt  = w_step_out;
                    w_pcnt_nxt = w_step_pcnt;
                    if (!w_en_s) begin
                        w_state_nxt = STOP_PEND;
                    end
                end
            end

            STOP_PEND: begin
                if (w_eop && w_burst_hit) begin
                    // Burst completion takes priority over a plain stop
                    w_state_nxt = DONE;
                    w_cnt_nxt   = '0;
                    w_out_nxt   = 1'b0;
                    w_done_nxt  = 1'b1;
                end else if (w_en_s) begin
                    // Enable came back: resume without touching the waveform
                    w_state_nxt = RUN;
                    w_cnt_nxt   = w_step_cnt;
                    w_out_nxt   = w_step_out;
                    w_pcnt_nxt  = w_step_pcnt;
                end else if (w_eop) begin
                    // Period finished: park low instead of rising again
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_pcnt_nxt  = '0;
                    w_out_nxt   = 1'b0;
                end else begin
                    w_cnt_nxt  = w_step_cnt;
                    w_out_nxt  = w_step_out;
                    w_pcnt_nxt = w_step_pcnt;
                end
            end

            DONE: begin
                w_out_nxt = 1'b0;
                // A new burst requires the enable to be released first
                if (!w_en_s) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_pcnt_nxt  = '0;
                end
            end

            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
                w_pcnt_nxt  = '0;
                w_out_nxt   = 1'b0;
            end
        endcase
    end

    // Register state, datapath and all outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_pcnt    <= '0;
            r_div_q   <= '0;
            r_burst_q <= '0;
            r_out     <= 1'b0;
            r_done    <= 1'b0;
            r_active  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pcnt    <= w_pcnt_nxt;
            r_div_q   <= w_div_nxt;
            r_burst_q <= w_burst_nxt;
            r_out     <= w_out_nxt;
            r_done    <= w_done_nxt;
            r_active  <= (w_state_nxt != IDLE);
        end
    end

    assign out_o    = r_out;
    assign active_o = r_active;
    assign done_o   = r_done;

endmodule : osc_div_chan
`default_nettype wire

// File: rtl/osc_div_gate.sv
`default_nettype none
// ============================================================================
//  Module      : osc_div_gate
//  Description : Multi-channel gated clock divider and burst generator for
//                the oscillator output path. Each channel is independent and
//                takes its divide ratio and burst length from its own field
//                of the packed configuration buses.
//  Revision    : 1.0 - initial release
// ============================================================================
module osc_div_gate
    import osc_pkg::*;
#(
    parameter int NCH         = c_def_nch,
    parameter int DIV_W       = c_def_div_w,
    parameter int CNT_W       = c_def_cnt_w,
    parameter int SYNC_STAGES = c_def_sync_stages
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       en_i,
    input  logic [NCH*DIV_W-1:0] div_i,
    input  logic [NCH*CNT_W-1:0] burst_i,
    output logic [NCH-1:0]       out_o,
    output logic [NCH-1:0]       active_o,
    output logic [NCH-1:0]       done_o
);

    // One self-contained channel per output, no shared timing between them
    for (genvar g = 0; g < NCH; g++) begin : g_chan
        osc_div_chan #(
            .DIV_W       (DIV_W),
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .en_i     (en_i[g]),
            .div_i    (div_i[slice_lo(g, DIV_W) +: DIV_W]),
            .burst_i  (burst_i[slice_lo(g, CNT_W) +: CNT_W]),
            .out_o    (out_o[g]),
            .active_o (active_o[g]),
            .done_o   (done_o[g])
        );
    end

endmodule : osc_div_gate
`default_nettype wire

// File: tb/tb_osc_div_gate.sv
`default_nettype none
// ============================================================================
//  Module      : tb_osc_div_gate
//  Description : Self-checking bench for osc_div_gate. A behavioural model
//                predicts every cycle's outputs from the enable history and
//                the period/burst arithmetic; a monitor compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_osc_div_gate;

    localparam int NCH  = 4;
    localparam int DW   = 8;
    localparam int CW   = 8;
    localparam int SYNC = 2;

    logic              clk;
    logic              rst_n;
    logic [NCH-1:0]    en_i;
    logic [NCH*DW-1:0] div_i;
    logic [NCH*CW-1:0] burst_i;
    logic [NCH-1:0]    out_o;
    logic [NCH-1:0]    active_o;
    logic [NCH-1:0]    done_o;

    int tests = 0;
    int fails = 0;

    osc_div_gate #(
        .NCH(NCH), .DIV_W(DW), .CNT_W(CW), .SYNC_STAGES(SYNC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en_i(en_i), .div_i(div_i),
        .burst_i(burst_i), .out_o(out_o), .active_o(active_o), .done_o(done_o)
    );

    initial clk = 1'b0;
    initial forever #5 clk = ~clk;

    // Scoreboard of expected {done, active, out}, one entry per clock
    logic [3*NCH-1:0] exp_q[$];

    // ---------------- reference model ----------------
    // Running channel: t counts cycles since the output first rose; the
    // output is high in the first (div+1) cycles of every 2*(div+1) period.
    logic [NCH-1:0] hist[$];       // enable delay line (synchroniser)
    bit             m_run  [NCH];
    bit             m_dn   [NCH];
    int             m_t    [NCH];
    int             m_div  [NCH];
    int             m_bst  [NCH];
    logic [NCH-1:0] m_last;        // synchronised enable one edge earlier

    always @(posedge clk) begin : model
        logic [NCH-1:0] es;
        logic [NCH-1:0] e_out, e_act, e_done;
        int h, p, ph, per;
        if (!rst_n) begin
            hist.delete();
            for (int i = 0; i < SYNC; i++) hist.push_back('0);
            for (int k = 0; k < NCH; k++) begin
                m_run[k] = 0; m_dn[k] = 0; m_t[k] = 0; m_div[k] = 0; m_bst[k] = 0;
            end
            m_last = '0;
        end else begin
            es = hist[0];
            e_done = '0;
            for (int k = 0; k < NCH; k++) begin
                if (m_run[k]) begin
                    h = m_div[k] + 1; p = 2 * h;
                    ph = m_t[k] % p; per = m_t[k] / p;
                    if (ph == p - 1 && m_bst[k] != 0 && ((per + 1) % (1 << CW)) == m_bst[k]) begin
                        m_run[k] = 0; m_dn[k] = 1; e_done[k] = 1'b1;
                    end else if (ph == p - 1 && !es[k] && !m_last[k]) begin
                        m_run[k] = 0;
                    end else begin
                        m_t[k]++;
                    end
                end else if (m_dn[k]) begin
                    if (!es[k]) m_dn[k] = 0;
                end else if (es[k]) begin
                    m_run[k] = 1; m_t[k] = 0;
                    m_div[k] = int'(div_i[k*DW +: DW]);
                    m_bst[k] = int'(burst_i[k*CW +: CW]);
                end
                h = m_div[k] + 1;
                e_out[k] = m_run[k] && ((m_t[k] % (2 * h)) < h);
                e_act[k] = m_run[k] || m_dn[k];
            end
            m_last = es;
            hist.push_back(en_i);
            void'(hist.pop_front());
            exp_q.push_back({e_done, e_act, e_out});
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        logic [3*NCH-1:0] e;
        if (!rst_n) begin
            exp_q.delete();
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if ({done_o, active_o, out_o} !== e) begin
                fails++;
                $display("FAIL cycle_check t=%0t {done,active,out} got %h expected %h",
                         $time, {done_o, active_o, out_o}, e);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_cfg(input int ch, input int dv, input int bs);
        div_i[ch*DW +: DW]   = DW'(dv);
        burst_i[ch*CW +: CW] = CW'(bs);
    endtask

    task automatic check_zero(input string name);
        tests++;
        if ({done_o, active_o, out_o} !== '0) begin
            fails++;
            $display("FAIL %s got %h expected 0", name, {done_o, active_o, out_o});
        end
    endtask

    task automatic wait_high(input int ch);
        int n = 0;
        while (out_o[ch] !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (out_o[ch] !== 1'b1) begin
            fails++;
            $display("FAIL wait_out%0d timeout got %b expected 1", ch, out_o[ch]);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        en_i    = 4'hF;
        div_i   = '0;
        burst_i = '0;
        #1 check_zero("reset_immediate");
        cycles(2);
        check_zero("reset_held");

        // Release with everything disabled: outputs stay idle
        en_i  = '0;
        rst_n = 1'b1;
        cycles(20);

        // Continuous divide: ch0 period 8, ch1 period 2
        set_cfg(0, 3, 0);
        set_cfg(1, 0, 0);
        en_i = 4'b0011;
        cycles(40);

        // New divide value while running must not take effect
        set_cfg(0, 7, 0);
        cycles(30);

        // Stop mid high phase; the current period completes
        wait_high(0);
        cycles(1);
        en_i[0] = 1'b0;
        cycles(30);

        // Restart picks up the new divide value (period 16)
        en_i[0] = 1'b1;
        cycles(40);

        // Drop and re-raise inside the stop-pending window
        wait_high(0);
        en_i[0] = 1'b0;
        cycles(4);
        en_i[0] = 1'b1;
        cycles(40);

        // Burst of 3 two-cycle pulses on ch2, then a second burst
        set_cfg(2, 1, 3);
        en_i[2] = 1'b1;
        cycles(30);
        en_i[2] = 1'b0;
        cycles(5);
        en_i[2] = 1'b1;
        cycles(30);

        // Asynchronous reset in the middle of a high phase
        en_i[2] = 1'b0;
        cycles(5);
        set_cfg(2, 3, 10);
        en_i[2] = 1'b1;
        wait_high(2);
        cycles(1);
        #2 rst_n = 1'b0;
        #1 check_zero("async_reset");
        cycles(2);
        rst_n = 1'b1;
        cycles(40);

        // Randomised enables and configuration on all channels
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            for (int k = 0; k < NCH; k++) begin
                if ($urandom_range(0, 39) == 0) en_i[k] = ~en_i[k];
                if ($urandom_range(0, 19) == 0) begin
                    set_cfg(k, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
                end
            end
        end

        cycles(3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_osc_div_gate
`default_nettype wire

// File: doc/osc_div_gate.md
Name: osc_div_gate

Overview:
- Multi-channel gated clock-divider and burst generator for the oscillator-output path of the analog front end.
- Replaces a bare AND-gate enable with:
  - glitch-free start and stop,
  - a per-channel programmable divide ratio,
  - an optional fixed-length pulse-burst mode.
- `clk` is the ring-oscillator or system clock. Channel outputs drive pads and test-mux inputs.

Parameters:
- NCH, 4, number of independent output channels
- DIV_W, 8, divider field width; half-period = div+1 clk cycles
- CNT_W, 8, burst-length field width; 0 = continuous
- SYNC_STAGES, 2, enable synchroniser depth (>=2)

Ports:
- clk  input  1  single block clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- en_i  input  NCH  per-channel enable, asynchronous to clk
- div_i  input  NCH*DIV_W  per-channel half-period minus 1; channel k at [k*DIV_W +: DIV_W]
- burst_i  input  NCH*CNT_W  per-channel pulse count; 0 = run continuously
- out_o  output  NCH  divided/gated oscillator outputs, registered
- active_o  output  NCH  channel not IDLE
- done_o  output  NCH  one-cycle pulse when a burst completes

Behaviour:
Clock and reset:
- One clock (`clk`). Reset is asynchronous and active-low (`rst_n`).
- `rst_n` low forces all of the following to 0 immediately (asynchronously): out_o, active_o, done_o, synchronisers, counters. FSM goes to IDLE.
- Reset mid-pulse truncates that pulse; this is accepted.

Synchronisation and latching:
- Each en_i bit passes through SYNC_STAGES flops; the result is en_s.
- div_i and burst_i are sampled only on the IDLE->RUN transition, into div_q and burst_q. Changes while not IDLE are ignored.

Per-channel FSM states: IDLE, RUN, STOP_PEND, DONE.
- IDLE: out=0, cnt=0, pcnt=0. If en_s=1, go RUN; out<=1, cnt<=0; latch div_q and burst_q.
- Latency: if en_i is first sampled high at edge 0, out_o is 1 after edge SYNC_STAGES.
- RUN, each cycle:
  - If cnt==div_q: cnt<=0, out<=~out. On each 1->0 toggle, pcnt<=pcnt+1 (wraps at CNT_W).
  - Otherwise cnt<=cnt+1.
  - Output period = 2*(div_q+1) cycles at 50% duty. div_q=0 gives clk/2.
- End-of-period point: out==0 and cnt==div_q, i.e. the cycle in which out would next rise.
- Burst end: in RUN at the end-of-period point with burst_q!=0 and pcnt==burst_q:
  - go DONE; out stays 0; done_o=1 for exactly that one transition cycle.
- en_s falls in RUN: go STOP_PEND. The divider keeps running.
  - At the end-of-period point go IDLE, holding out at 0. The last high pulse is always full width.
- STOP_PEND with en_s back to 1: return to RUN with no disturbance to cnt or out.
- Stop and burst end on the same cycle: burst end wins (go DONE, assert done_o). The channel then leaves DONE once en_s is already 0.
- DONE: out=0. Stay until en_s=0, then go IDLE. A new burst needs en_i to toggle low then high.
- active_o = (state != IDLE). It is registered together with the state.
- Channels are fully independent. There is no phase alignment between channels.

Decomposition:
- Package osc_pkg holds:
  - the state enum (IDLE, RUN, STOP_PEND, DONE),
  - default parameter constants,
  - a slice-index helper for the packed div and burst buses.
- Sub-module osc_div_chan holds one channel: synchroniser, FSM, cnt, pcnt, latched div and burst.
- Top-level osc_div_gate instantiates NCH copies in a generate loop and slices the buses.

Test Plan:
- Reset and idle: rst_n=0 with en_i=4'hF -> out_o, active_o, done_o = 0. Release rst_n and hold en_i=0 for 20 cycles -> outputs stay 0.
- Continuous divide: ch0 div=3, burst=0, en rises at edge 0 -> out_o[0] high after edge 2; 4 high / 4 low cycles; period 8. Check ch1 div=0 in parallel -> period 2.
- Glitch-free stop: ch0 div=3, drop en mid high phase -> high phase completes to 4 cycles, low phase completes to 4 cycles, then IDLE; active_o[0] falls together with the state change. Re-raise en inside STOP_PEND -> waveform continuous, no short pulse.
- Burst: ch2 div=1, burst=3 -> exactly 3 pulses of 2 cycles high; done_o[2] high for 1 cycle at the end of the 3rd low phase; out stays 0 while en stays high. Toggle en low then high -> a second 3-pulse burst.
- Config isolation: change div_i[0] from 3 to 7 while RUN -> period stays 8. Stop and restart -> period becomes 16.
- Async reset mid-burst: assert rst_n low in the middle of a high phase -> out_o goes 0 without waiting for a clock edge. After release with en held high -> restarts after SYNC_STAGES edges with pcnt=0.
